// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, issues word reads to a synchronous instruction memory and
// buffers returned words for decode behind a valid/ready handshake with redirect flush.
module instruction_fetch #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] ResetPc = ADDR_WIDTH'(RESET_PC);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [ADDR_WIDTH-1:0] pcs_q  [DEPTH];
  logic [ADDR_WIDTH-1:0] pcs_d  [DEPTH];

  logic          pop, push, issue;
  logic [CntW:0] occ;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    ptr_inc = (32'(p) == DEPTH - 1) ? '0 : p + PtrW'(1);
  endfunction

  assign pop  = instr_valid & instr_ready;
  assign push = inflight_q;
  // Occupancy after this edge's push/pop; a new issue needs a free slot for its response.
  assign occ   = {1'b0, count_q} + (CntW + 1)'(push) - (CntW + 1)'(pop);
  assign issue = (32'(occ) + 32'd1) <= DEPTH;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    data_d        = data_q;
    pcs_d         = pcs_q;
    if (redirect_valid) begin
      // Keep the head so the stale outputs still show the last head entry.
      pc_d    = redirect_addr;
      count_d = '0;
      tail_d  = head_q;
    end else begin
      if (push) begin
        data_d[tail_q] = imem_data;
        pcs_d[tail_q]  = inflight_pc_q;
        tail_d         = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= ResetPc;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        pcs_q[i]  <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      data_q        <= data_d;
      pcs_q         <= pcs_d;
    end
  end

  // Outputs are forced to their reset values while reset is held.
  assign imem_addr   = reset ? ResetPc : pc_q;
  assign instr_valid = !reset && (count_q != '0);
  assign instr       = reset ? '0 : data_q[head_q];
  assign instr_pc    = reset ? '0 : pcs_q[head_q];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: synchronous memory model plus an in-order expected-PC stream model.
module tb_instruction_fetch;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;

  int            tests_run = 0;
  int            tests_failed = 0;
  logic [AW-1:0] exp_pc;

  instruction_fetch #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (2),
    .RESET_PC  (0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: mem[i] = A000_0000 + i.
  always @(posedge clk) imem_data <= 32'hA000_0000 + 32'(imem_addr);

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0;
    tick(); tick();
    tests_run++;
    if ({instr_valid, instr, instr_pc} !== {1'b0, 32'h0, 10'h0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%0b i=%h pc=%h, expected v=0 i=0 pc=0",
               instr_valid, instr, instr_pc);
    end
    tests_run++;
    if (imem_addr !== 10'h0) begin
      tests_failed++;
      $display("FAIL reset_addr: got %h expected 000", imem_addr);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if (instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_cycle1: instr_valid got %0b expected 0", instr_valid);
    end
    tick();
    exp_pc = '0;
    tests_run++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, word_at(exp_pc)}) begin
      tests_failed++;
      $display("FAIL latency_cycle2: got v=%0b pc=%h i=%h expected v=1 pc=%h i=%h",
               instr_valid, instr_pc, instr, exp_pc, word_at(exp_pc));
    end
  endtask

  task automatic test_stream();
    instr_ready = 1'b1;
    repeat (4) begin
      tests_run++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, word_at(exp_pc)}) begin
        tests_failed++;
        $display("FAIL stream: got v=%0b pc=%h i=%h expected v=1 pc=%h i=%h",
                 instr_valid, instr_pc, instr, exp_pc, word_at(exp_pc));
      end
      exp_pc++;
      tick();
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, word_at(exp_pc)}) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got v=%0b pc=%h i=%h expected v=1 pc=%h i=%h", i,
                 instr_valid, instr_pc, instr, exp_pc, word_at(exp_pc));
      end
      // Two words buffered, so the next fetch address is parked two past the head.
      tests_run++;
      if (imem_addr !== exp_pc + 10'd2) begin
        tests_failed++;
        $display("FAIL stall_no_issue[%0d]: imem_addr got %h expected %h", i, imem_addr,
                 exp_pc + 10'd2);
      end
    end
    instr_ready = 1'b1;
    repeat (3) begin
      tests_run++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, word_at(exp_pc)}) begin
        tests_failed++;
        $display("FAIL stall_release: got v=%0b pc=%h i=%h expected v=1 pc=%h i=%h",
                 instr_valid, instr_pc, instr, exp_pc, word_at(exp_pc));
      end
      exp_pc++;
      tick();
    end
  endtask

  task automatic test_redirect();
    instr_ready = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_addr  = 10'h200;
    tick();
    redirect_valid = 1'b0;
    exp_pc = 10'h200;
    tests_run++;
    if ({instr_valid, imem_addr} !== {1'b0, exp_pc}) begin
      tests_failed++;
      $display("FAIL redirect_flush: got v=%0b addr=%h expected v=0 addr=%h",
               instr_valid, imem_addr, exp_pc);
    end
    tick();
    tests_run++;
    if (instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL redirect_gap: instr_valid got %0b expected 0", instr_valid);
    end
    tick();
    instr_ready = 1'b1;
    repeat (4) begin
      tests_run++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, word_at(exp_pc)}) begin
        tests_failed++;
        $display("FAIL redirect_target: got v=%0b pc=%h i=%h expected v=1 pc=%h i=%h",
                 instr_valid, instr_pc, instr, exp_pc, word_at(exp_pc));
      end
      exp_pc++;
      tick();
    end
  endtask

  task automatic test_redirect_pop(input logic [AW-1:0] target, input string name);
    instr_ready = 1'b0;
    tick(); tick();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = target;
    tests_run++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, word_at(exp_pc)}) begin
      tests_failed++;
      $display("FAIL %s_pop: got v=%0b pc=%h i=%h expected v=1 pc=%h i=%h", name,
               instr_valid, instr_pc, instr, exp_pc, word_at(exp_pc));
    end
    exp_pc = target;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (instr_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_gap[%0d]: instr_valid got %0b expected 0", name, i, instr_valid);
      end
      tick();
    end
    repeat (4) begin
      tests_run++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, word_at(exp_pc)}) begin
        tests_failed++;
        $display("FAIL %s_stream: got v=%0b pc=%h i=%h expected v=1 pc=%h i=%h", name,
                 instr_valid, instr_pc, instr, exp_pc, word_at(exp_pc));
      end
      exp_pc++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    tests_run++;
    if ({instr_valid, imem_addr} !== {1'b0, 10'h0}) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got v=%0b addr=%h expected v=0 addr=000",
               instr_valid, imem_addr);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if (instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_gap: instr_valid got %0b expected 0", instr_valid);
    end
    tick();
    exp_pc = '0;
    tests_run++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, word_at(exp_pc)}) begin
      tests_failed++;
      $display("FAIL midreset_restart: got v=%0b pc=%h i=%h expected v=1 pc=000 i=%h",
               instr_valid, instr_pc, instr, word_at(exp_pc));
    end
  endtask

  task automatic test_random();
    logic          prev_hold = 1'b0;
    logic [AW-1:0] prev_pc = '0;
    logic [DW-1:0] prev_instr = '0;
    logic          redir;
    int            gap = 0;
    for (int n = 0; n < 400; n++) begin
      if (prev_hold) begin
        tests_run++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, prev_pc, prev_instr}) begin
          tests_failed++;
          $display("FAIL rand_stable[%0d]: got v=%0b pc=%h i=%h expected v=1 pc=%h i=%h", n,
                   instr_valid, instr_pc, instr, prev_pc, prev_instr);
        end
      end
      if (!instr_valid) begin
        gap++;
        tests_run++;
        if (gap > 2) begin
          tests_failed++;
          $display("FAIL rand_bubble[%0d]: %0d invalid cycles, at most 2 allowed", n, gap);
        end
      end else begin
        gap = 0;
      end
      instr_ready = ($urandom_range(0, 3) != 0);
      redir       = ($urandom_range(0, 19) == 0);
      if (instr_valid && instr_ready) begin
        tests_run++;
        if ({instr_pc, instr} !== {exp_pc, word_at(exp_pc)}) begin
          tests_failed++;
          $display("FAIL rand_order[%0d]: got pc=%h i=%h expected pc=%h i=%h", n,
                   instr_pc, instr, exp_pc, word_at(exp_pc));
        end
        exp_pc++;
      end
      prev_hold  = instr_valid && !instr_ready && !redir;
      prev_pc    = instr_pc;
      prev_instr = instr;
      redirect_valid = redir;
      if (redir) begin
        redirect_addr = AW'($urandom_range(0, 1023));
        exp_pc        = redirect_addr;
        gap           = 0;
      end
      tick();
    end
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop(AW'($urandom_range(16, 1000)), "redir_pop");
    test_redirect_pop(10'd1022, "wrap");
    test_reset_mid();
    test_random();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
